// File: rtl/ctrl_pkg.sv
// Shared definitions for the fetch/decode block.
// Contents: supported opcode constants, ALUOp encodings, the fetch/decode
// FSM state enum, the control-bundle struct, and a PC alignment helper.
package ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        ISSUE   = 2'd2,
        WAIT_BR = 2'd3
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Every PC update lands on a word boundary.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ctrl_decode_lut.sv
// Opcode -> control bundle lookup (purely combinational).
// Ports:
//   opcode  in  7       instruction bits [6:0]
//   ctrl    out CTRL_W  packed ctrl_t bundle (all zero for unsupported opcodes)
//   legal   out 1       opcode is one of R-type, lw, sw, beq
import ctrl_pkg::*;

module ctrl_decode_lut (
    input  logic [6:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              legal
);

    ctrl_t c;

    always_comb begin
        c     = '0;
        legal = 1'b1;
        case (opcode)
            OPC_RTYPE: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            OPC_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALUOP_MEM;
            end
            OPC_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_MEM;
            end
            OPC_BRANCH: begin
                c.pc_src = 1'b1;
                c.alu_op = ALUOP_BRANCH;
            end
            default: legal = 1'b0;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch / decode front end for a small RV32 subset.
// Fetches a word from instruction memory, decodes it in one cycle, presents
// the decoded fields and controls to the datapath with a valid/ready
// handshake, and resolves beq through br_valid/br_taken.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata  instruction memory fetch
//   issue_valid/issue_ready                 decoded-instruction handshake
//   rs1, rs2, rd, func3, func7, imm         decoded fields (imm: I/S imm, B offset[12:1])
//   RegWrite..ALUOp0                        datapath controls, zero unless issue_valid
//   br_valid/br_taken                       branch resolution
//   pc                                      byte address of current instruction
//   illegal                                 one-cycle pulse on an unsupported opcode
import ctrl_pkg::*;

module instr_fetch_decode #(
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [2:0]         func3,
    output logic [6:0]         func7,
    output logic [11:0]        imm,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               PCSrc,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               ALUOp1,
    output logic               ALUOp0,
    input  logic               br_valid,
    input  logic               br_taken,
    output logic [31:0]        pc,
    output logic               illegal
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [4:0]  rs1_reg, rs2_reg, rd_reg;
    logic [2:0]  func3_reg;
    logic [6:0]  func7_reg;
    logic [11:0] imm_reg;
    ctrl_t       ctrl_reg;
    logic        illegal_reg;

    ctrl_t       lut_ctrl;
    logic        lut_legal;
    logic [11:0] imm_dec;
    logic [31:0] pc_seq;
    logic [31:0] pc_target;

    ctrl_decode_lut u_lut (
        .opcode (instr_reg[6:0]),
        .ctrl   (lut_ctrl),
        .legal  (lut_legal)
    );

    // Immediate layout depends on format; B-type keeps offset[12:1].
    always_comb begin
        imm_dec = instr_reg[31:20];
        case (instr_reg[6:0])
            OPC_STORE:  imm_dec = {instr_reg[31:25], instr_reg[11:7]};
            OPC_BRANCH: imm_dec = {instr_reg[31], instr_reg[7], instr_reg[30:25], instr_reg[11:8]};
            default:    imm_dec = instr_reg[31:20];
        endcase
    end

    assign pc_seq    = pc_align(pc_reg + 32'd4);
    assign pc_target = pc_align(pc_reg + {{19{imm_reg[11]}}, imm_reg, 1'b0});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   if (imem_ack) state_next = DECODE;
            DECODE:  state_next = lut_legal ? ISSUE : FETCH;
            // ctrl_reg.pc_src is only set for beq, so it selects the branch path.
            ISSUE:   if (issue_ready) state_next = ctrl_reg.pc_src ? WAIT_BR : FETCH;
            WAIT_BR: if (br_valid) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg      <= RESET_PC;
            instr_reg   <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            rd_reg      <= '0;
            func3_reg   <= '0;
            func7_reg   <= '0;
            imm_reg     <= '0;
            ctrl_reg    <= '0;
            illegal_reg <= 1'b0;
        end else begin
            illegal_reg <= 1'b0;
            case (state_reg)
                FETCH: begin
                    if (imem_ack) instr_reg <= imem_rdata;
                end
                DECODE: begin
                    if (lut_legal) begin
                        rs1_reg   <= instr_reg[19:15];
                        rs2_reg   <= instr_reg[24:20];
                        rd_reg    <= instr_reg[11:7];
                        func3_reg <= instr_reg[14:12];
                        func7_reg <= instr_reg[31:25];
                        imm_reg   <= imm_dec;
                        ctrl_reg  <= lut_ctrl;
                    end else begin
                        // Fields keep the last legal instruction's values.
                        illegal_reg <= 1'b1;
                        pc_reg      <= pc_seq;
                    end
                end
                ISSUE: begin
                    if (issue_ready && !ctrl_reg.pc_src) pc_reg <= pc_seq;
                end
                WAIT_BR: begin
                    if (br_valid) pc_reg <= br_taken ? pc_target : pc_seq;
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state_reg == FETCH);
    assign imem_addr   = pc_reg[IMEM_AW+1:2];
    assign issue_valid = (state_reg == ISSUE);
    assign pc          = pc_reg;
    assign illegal     = illegal_reg;

    assign rs1   = rs1_reg;
    assign rs2   = rs2_reg;
    assign rd    = rd_reg;
    assign func3 = func3_reg;
    assign func7 = func7_reg;
    assign imm   = imm_reg;

    assign RegWrite = issue_valid & ctrl_reg.reg_write;
    assign ALUSrc   = issue_valid & ctrl_reg.alu_src;
    assign PCSrc    = issue_valid & ctrl_reg.pc_src;
    assign MemRead  = issue_valid & ctrl_reg.mem_read;
    assign MemWrite = issue_valid & ctrl_reg.mem_write;
    assign MemToReg = issue_valid & ctrl_reg.mem_to_reg;
    assign ALUOp1   = issue_valid & ctrl_reg.alu_op[1];
    assign ALUOp0   = issue_valid & ctrl_reg.alu_op[0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed testbench for instr_fetch_decode.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [11:0] imm;
    logic        RegWrite, ALUSrc, PCSrc, MemRead, MemWrite, MemToReg, ALUOp1, ALUOp0;
    logic        br_valid, br_taken;
    logic [31:0] pc;
    logic        illegal;

    logic [31:0] mem [0:255];
    logic        ack_en;
    logic        ack_force;
    logic [7:0]  ctrl_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_ack   = ack_force | (ack_en & imem_req);
    assign imem_rdata = mem[imem_addr];
    // RegWrite ALUSrc MemToReg MemRead MemWrite PCSrc ALUOp1 ALUOp0
    assign ctrl_v = {RegWrite, ALUSrc, MemToReg, MemRead, MemWrite, PCSrc, ALUOp1, ALUOp0};

    instr_fetch_decode #(.IMEM_AW(8), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func3       (func3),
        .func7       (func7),
        .imm         (imm),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .PCSrc       (PCSrc),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .ALUOp1      (ALUOp1),
        .ALUOp0      (ALUOp0),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .pc          (pc),
        .illegal     (illegal)
    );

    // Step negedges until issue_valid, up to 20; n = -1 on timeout.
    task automatic wait_issue(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (issue_valid) break;
        end
        if (!issue_valid) n = -1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        issue_ready = 1'b0;
        br_valid    = 1'b0;
        br_taken    = 1'b0;
        ack_en      = 1'b1;
        ack_force   = 1'b0;
        #1 reset = 1'b0;
        #11;
        checks++;
        if ({pc, issue_valid, illegal} !== {32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: pc=%h valid=%b illegal=%b, expected pc=0 valid=0 illegal=0", pc, issue_valid, illegal);
        end
        checks++;
        if ({ctrl_v, rs1, rs2, rd, func3, func7, imm} !== 45'h0) begin
            errors++;
            $display("FAIL reset_outputs: ctrl=%b rs1=%0d rs2=%0d rd=%0d imm=%h, expected all zero", ctrl_v, rs1, rs2, rd, imm);
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_fetch: req=%b addr=%h, expected req=1 addr=00", imem_req, imem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("reset: pc=%h req=%b addr=%h", pc, imem_req, imem_addr);
    endtask

    task automatic test_rtype();
        int n;
        issue_ready = 1'b1;
        wait_issue(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL rtype_latency: got %0d cycles, expected 2", n);
        end
        checks++;
        if ({rs1, rs2, rd, func3, func7} !== {5'd1, 5'd2, 5'd3, 3'd0, 7'd0}) begin
            errors++;
            $display("FAIL rtype_fields: rs1=%0d rs2=%0d rd=%0d f3=%0d f7=%0d, expected 1 2 3 0 0", rs1, rs2, rd, func3, func7);
        end
        checks++;
        if ({ctrl_v, pc} !== {8'b1000_0010, 32'h0}) begin
            errors++;
            $display("FAIL rtype_ctrl: ctrl=%b pc=%h, expected ctrl=10000010 pc=0", ctrl_v, pc);
        end
        $display("add x3,x1,x2: pc=%h rs1=%0d rs2=%0d rd=%0d ctrl=%b", pc, rs1, rs2, rd, ctrl_v);
        @(negedge clk);
        checks++;
        if ({issue_valid, ctrl_v, imem_req, imem_addr, rd} !== {1'b0, 8'h00, 1'b1, 8'h01, 5'd3}) begin
            errors++;
            $display("FAIL rtype_next: valid=%b ctrl=%b req=%b addr=%h rd=%0d, expected 0 0 1 01 3", issue_valid, ctrl_v, imem_req, imem_addr, rd);
        end
    endtask

    task automatic test_load_store();
        int n;
        wait_issue(n);
        checks++;
        if ({imm, ctrl_v, rd, rs1, pc} !== {12'h008, 8'b1111_0000, 5'd5, 5'd1, 32'h4}) begin
            errors++;
            $display("FAIL lw_decode: imm=%h ctrl=%b rd=%0d rs1=%0d pc=%h, expected 008 11110000 5 1 4", imm, ctrl_v, rd, rs1, pc);
        end
        $display("lw x5,8(x1): pc=%h imm=%h ctrl=%b", pc, imm, ctrl_v);
        wait_issue(n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL throughput: got %0d cycles between issues, expected 3", n);
        end
        checks++;
        if ({imm, ctrl_v, rs2, rs1, pc} !== {12'h00C, 8'b0100_1000, 5'd5, 5'd1, 32'h8}) begin
            errors++;
            $display("FAIL sw_decode: imm=%h ctrl=%b rs2=%0d rs1=%0d pc=%h, expected 00c 01001000 5 1 8", imm, ctrl_v, rs2, rs1, pc);
        end
        $display("sw x5,12(x1): pc=%h imm=%h ctrl=%b", pc, imm, ctrl_v);
    endtask

    task automatic test_illegal();
        int          ill_cnt = 0;
        bit          saw_valid = 1'b0;
        logic [31:0] ill_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (illegal) begin
                ill_cnt++;
                ill_pc = pc;
            end
            if (issue_valid) saw_valid = 1'b1;
        end
        issue_ready = 1'b0;
        checks++;
        if (ill_cnt !== 1) begin
            errors++;
            $display("FAIL illegal_pulse: high for %0d cycles, expected 1", ill_cnt);
        end
        checks++;
        if ({saw_valid, ill_pc} !== {1'b0, 32'h10}) begin
            errors++;
            $display("FAIL illegal_effect: saw_valid=%b pc=%h, expected 0 and 00000010", saw_valid, ill_pc);
        end
        $display("illegal 0x00000013: pulses=%0d pc_after=%h", ill_cnt, ill_pc);
    endtask

    task automatic test_stall_branch();
        int          n;
        bit          stall_bad = 1'b0;
        logic [44:0] snap;
        wait_issue(n);
        checks++;
        if ({imm, ctrl_v, rs1, rs2, pc} !== {12'h008, 8'b0000_0101, 5'd1, 5'd2, 32'h10}) begin
            errors++;
            $display("FAIL beq_decode: imm=%h ctrl=%b rs1=%0d rs2=%0d pc=%h, expected 008 00000101 1 2 10", imm, ctrl_v, rs1, rs2, pc);
        end
        snap = {rs1, rs2, rd, func3, func7, imm, ctrl_v};
        // A branch result while still in ISSUE must be ignored.
        br_valid = 1'b1;
        br_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!issue_valid || pc !== 32'h10 || {rs1, rs2, rd, func3, func7, imm, ctrl_v} !== snap) stall_bad = 1'b1;
        end
        checks++;
        if (stall_bad !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: outputs changed while issue_ready=0 (valid=%b pc=%h), expected stable", issue_valid, pc);
        end
        br_valid    = 1'b0;
        issue_ready = 1'b1;
        @(negedge clk);
        issue_ready = 1'b0;
        checks++;
        if ({issue_valid, ctrl_v, imem_req, pc} !== {1'b0, 8'h00, 1'b0, 32'h10}) begin
            errors++;
            $display("FAIL wait_br_entry: valid=%b ctrl=%b req=%b pc=%h, expected 0 0 0 10", issue_valid, ctrl_v, imem_req, pc);
        end
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_req, pc} !== {1'b0, 32'h10}) begin
            errors++;
            $display("FAIL wait_br_ack_ignored: req=%b pc=%h, expected 0 10", imem_req, pc);
        end
        br_valid = 1'b1;
        br_taken = 1'b1;
        @(negedge clk);
        br_valid = 1'b0;
        checks++;
        if ({pc, imem_addr, imem_req} !== {32'h20, 8'h08, 1'b1}) begin
            errors++;
            $display("FAIL beq_taken: pc=%h addr=%h req=%b, expected 20 08 1", pc, imem_addr, imem_req);
        end
        $display("beq taken: pc=%h addr=%h", pc, imem_addr);
    endtask

    task automatic test_not_taken_reset();
        bit found = 1'b0;
        apply_reset();
        issue_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (issue_valid && PCSrc) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if ({found, pc} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL rerun_beq: found=%b pc=%h, expected 1 10", found, pc);
        end
        @(negedge clk);
        br_valid = 1'b1;
        br_taken = 1'b0;
        @(negedge clk);
        br_valid = 1'b0;
        checks++;
        if ({pc, imem_addr} !== {32'h14, 8'h05}) begin
            errors++;
            $display("FAIL beq_not_taken: pc=%h addr=%h, expected 14 05", pc, imem_addr);
        end
        $display("beq not taken: pc=%h addr=%h", pc, imem_addr);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (issue_valid && PCSrc) begin
                found = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if ({found, imem_req, pc} !== {1'b1, 1'b0, 32'h14}) begin
            errors++;
            $display("FAIL second_beq_wait: found=%b req=%b pc=%h, expected 1 0 14", found, imem_req, pc);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, pc, issue_valid} !== {1'b1, 8'h00, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_wait_br: req=%b addr=%h pc=%h valid=%b, expected 1 00 0 0", imem_req, imem_addr, pc, issue_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("reset in WAIT_BR: addr=%h pc=%h", imem_addr, pc);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0020_81B3;  // add x3,x1,x2
        mem[1] = 32'h0080_A283;  // lw  x5,8(x1)
        mem[2] = 32'h0050_A623;  // sw  x5,12(x1)
        mem[3] = 32'h0000_0013;  // unsupported opcode
        mem[4] = 32'h0020_8863;  // beq x1,x2,+16
        mem[5] = 32'h0020_8863;  // beq x1,x2,+16
        test_reset();
        test_rtype();
        test_load_store();
        test_illegal();
        test_stall_branch();
        test_not_taken_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
